conv_tile_sequencer: RTL and testbench
======================================

# conv_tile_sequencer

Controller that sequences a 4x4 pixel table buffer for a 3x3 convolution. Accepts a 128-bit tile with its 72-bit kernel, drives the buffer load strobe and row/col read address, and multiply-accumulates the 9 taps for each of the 4 valid window positions. Emits 4 signed results per tile over a valid/ready handshake. Sits between the tile fetch stage and the result writer, and is the only master of the buffer's `ld`/`row`/`col`.

## Interface
- `ACC_W`, 21: accumulator and result width. Must be ≥21; elaboration error otherwise.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tile_valid` input 1: upstream tile and kernel present.
- `tile_ready` output 1: sequencer can accept a tile.
- `kernel_in` input 72: 3x3 signed 8-bit weights. w0=[71:64] (kernel[0][0]) … w8=[7:0] (kernel[2][2]), row-major, MSB-first.
- `buf_ld` output 1: buffer load strobe. The 128-bit tile goes straight to the buffer.
- `buf_row` output 2: buffer read row.
- `buf_col` output 2: buffer read col.
- `pix_in` input 8: unsigned pixel from the buffer. Combinational read of `buf_row`/`buf_col` in the same cycle.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts result.
- `out_data` output ACC_W: signed convolution result.
- `out_idx` output 2: window position {wr,wc}.
- `out_last` output 1: high with the 4th result of a tile.

## Operation
- States: IDLE, SCAN, EMIT.
- **IDLE**
  - `tile_ready`=1.
  - `buf_ld` = `tile_valid && tile_ready` (combinational), so the buffer captures on the handshake edge.
  - On handshake: latch `kernel_in`, clear window (wr,wc)=(0,0), tap k=0, acc=0, go to SCAN.
- **SCAN**
  - kr=k/3, kc=k%3.
  - `buf_row`=wr+kr, `buf_col`=wc+kc.
  - Each cycle: acc += {1'b0,pix_in} × w[k], a signed 9×8 product sign-extended to ACC_W.
  - k=0..8. On k=8, register the final sum to `out_data` and go to EMIT.
- **EMIT**
  - `out_valid`=1; `out_idx`={wr,wc}; `out_last`=1 when (wr,wc)=(1,1).
  - On `out_ready`: advance window (0,0)→(0,1)→(1,0)→(1,1), clear acc and k, and go to SCAN.
  - After (1,1), go to IDLE instead.
- `buf_row`/`buf_col` = 0 outside SCAN.
- `tile_ready` = 0 in SCAN/EMIT. `tile_valid` is ignored there.
- `out_data`, `out_idx` and `out_last` stay stable while `out_valid && !out_ready`. No buffer reads occur while stalled.
- `out_ready` is ignored when `out_valid`=0.
- Value range: 255×127×9=291465 and 255×(−128)×9=−293760, so no overflow at ACC_W=21.

## Timing
- Reset values: `tile_ready`=0 during reset, then 1 in IDLE. `buf_ld`=0, `buf_row`=`buf_col`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0. State=IDLE, all counters 0.
- Reset mid-operation:
  - Partial results are discarded and `out_valid` drops immediately.
  - The kernel register is cleared.
  - The buffer is reset by the same `rst`.
- Timeline (cycles from handshake edge = cycle 0):
  - Taps read in cycles 1–9.
  - `out_valid` rises in cycle 10.
  - With `out_ready` held high, each window takes 10 cycles (9 SCAN + 1 EMIT).
  - `out_last` appears in cycle 40.
  - IDLE in cycle 41; next tile accepted no earlier than cycle 41.
- Each EMIT cycle with `out_ready` low adds exactly one cycle of latency.

## Configuration
- `CONV_RELU_EN` defined: EMIT outputs max(result, 0). Negative sums are presented as 0; `out_idx`/`out_last` are unchanged.
- `CONV_RELU_EN` undefined: the raw signed sum is output.
- Cycle timing is identical in both builds.

## Test plan
- **All ones:** pixels all 0x01, kernel all 0x01, `out_ready`=1 → four results of 9 in cycles 10/20/30/40. `out_idx` 0,1,2,3; `out_last` only on the 4th.
- **Address walk:** pixel[i][j]=4i+j (in=128'h000102…0F), kernel w4=1, all other weights 0 → results 5, 6, 9, 10. Trace `buf_row`/`buf_col` against the expected 36 addresses.
- **Negative sums:** pixels 0xFF, kernel all 0x80 → each result −293760. With `CONV_RELU_EN`, each result is 0.
- **Backpressure:** `out_ready` low for 5 cycles at the 2nd result → `out_data`=value held, `buf_row`/`buf_col`=0, `out_last` at cycle 45. A `tile_valid` pulse during this stall is not accepted (`buf_ld` stays 0).
- **Reset mid-SCAN:** assert `rst` at cycle 14 → all outputs at reset values. A subsequent tile with kernel w0=2 and pixels 0x03 gives result 6 at cycle 10 after its handshake.
- **Back-to-back tiles:** `tile_valid` held high with 2 tiles → second handshake exactly at cycle 41, `buf_ld` high only on the two handshake cycles.

Source files
------------

// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer: walks a 4x4 pixel buffer through a 3x3 convolution, one tap per cycle.
// Optional feature macro: CONV_RELU_EN clamps negative results to zero.
module conv_tile_sequencer #(
   parameter int ACC_W = 21
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tile_valid,
   output logic                    tile_ready,
   input  logic [71:0]             kernel_in,
   output logic                    buf_ld,
   output logic [1:0]              buf_row,
   output logic [1:0]              buf_col,
   input  logic [7:0]              pix_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic [1:0]              out_idx,
   output logic                    out_last
);

   typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

   state_t                  state, state_next;
   logic [0:8][7:0]         kern;
   logic [3:0]              k;
   logic                    wr, wc;
   logic [1:0]              kr, kc;
   logic                    last_tap;
   logic signed [ACC_W-1:0] acc, product, sum, result;

   generate
      if (ACC_W < 21) begin : g_acc_w_check
         $error("conv_tile_sequencer: ACC_W must be at least 21");
      end
   endgenerate

   always_comb begin
      kr = 2'd0;
      kc = k[1:0];
      if (k >= 4'd6) begin
         kr = 2'd2;
         kc = 2'(k - 4'd6);
      end else if (k >= 4'd3) begin
         kr = 2'd1;
         kc = 2'(k - 4'd3);
      end
   end

   // Pixel is unsigned, so it is zero-extended before the signed multiply.
   assign last_tap = (k == 4'd8);
   assign product  = ACC_W'($signed({1'b0, pix_in})) * ACC_W'($signed(kern[k]));
   assign sum      = acc + product;

`ifdef CONV_RELU_EN
   assign result = sum[ACC_W-1] ? '0 : sum;
`else
   assign result = sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         kern     <= '0;
         k        <= 4'd0;
         wr       <= 1'b0;
         wc       <= 1'b0;
         acc      <= '0;
         out_data <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (buf_ld) begin
                  kern <= kernel_in;
                  k    <= 4'd0;
                  wr   <= 1'b0;
                  wc   <= 1'b0;
                  acc  <= '0;
               end
            end
            SCAN: begin
               if (last_tap) begin
                  out_data <= result;
               end else begin
                  acc <= sum;
                  k   <= k + 4'd1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  {wr, wc} <= {wr, wc} + 2'd1;
                  k        <= 4'd0;
                  acc      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Reads only happen in SCAN, so a stalled EMIT leaves the buffer address at zero.
   always_comb begin
      state_next = state;
      tile_ready = 1'b0;
      buf_ld     = 1'b0;
      buf_row    = 2'd0;
      buf_col    = 2'd0;
      out_valid  = 1'b0;
      out_idx    = 2'd0;
      out_last   = 1'b0;
      case (state)
         IDLE: begin
            tile_ready = !rst;
            buf_ld     = tile_valid && !rst;
            if (tile_valid && !rst)
               state_next = SCAN;
         end
         SCAN: begin
            buf_row = {1'b0, wr} + kr;
            buf_col = {1'b0, wc} + kc;
            if (last_tap)
               state_next = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            out_idx   = {wr, wc};
            out_last  = wr & wc;
            if (out_ready)
               state_next = (wr & wc) ? IDLE : SCAN;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Testbench for conv_tile_sequencer: directed and random tiles against a cycle-scheduled convolution model.
// The 4x4 pixel buffer is modelled here and reset by the same rst.
module tb_conv_tile_sequencer;

   logic               clk = 1'b0;
   logic               rst;
   logic               tile_valid;
   logic               tile_ready;
   logic [71:0]        kernel_in;
   logic [127:0]       tile_in;
   logic               buf_ld;
   logic [1:0]         buf_row;
   logic [1:0]         buf_col;
   logic [7:0]         pix_in;
   logic               out_valid;
   logic               out_ready;
   logic signed [20:0] out_data;
   logic [1:0]         out_idx;
   logic               out_last;
   logic [0:15][7:0]   buf_mem;

   int n_checks = 0;
   int n_errors = 0;

   conv_tile_sequencer #(.ACC_W(21)) dut (
      .clk        (clk),
      .rst        (rst),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .kernel_in  (kernel_in),
      .buf_ld     (buf_ld),
      .buf_row    (buf_row),
      .buf_col    (buf_col),
      .pix_in     (pix_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst)
         buf_mem <= '0;
      else if (buf_ld)
         buf_mem <= tile_in;
   end

   assign pix_in = buf_mem[{buf_row, buf_col}];

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference convolution for window n = {wr,wc}, straight from pixel and weight arithmetic.
   function automatic longint convRef(input logic [127:0] tile, input logic [71:0] kern, input int n);
      longint s = 0;
      int     wr = n / 2;
      int     wc = n % 2;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            int p = int'(tile[127 - 8 * ((wr + r) * 4 + wc + c) -: 8]);
            int w = int'($signed(kern[71 - 8 * (r * 3 + c) -: 8]));
            s += longint'(p) * longint'(w);
         end
      end
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   function automatic logic [127:0] randTile();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [71:0] randKern();
      return 72'({$urandom, $urandom, $urandom});
   endfunction

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tile_valid = 1'b0;
         out_ready  = 1'($urandom % 2);
         #1;
         checkOutput("idle_tile_ready", longint'(tile_ready), 1);
         checkOutput("idle_buf_ld", longint'(buf_ld), 0);
      end
   endtask

   // noise: tile_valid during the tile is 0 = low, 1 = high, 2 = random.
   // abort_at: cycle at which rst is pulsed mid-tile (0 = never).
   task automatic applyStimulus(input logic [127:0] tile, input logic [71:0] kern,
                                input int st0, input int st1, input int st2, input int st3,
                                input int noise, input int abort_at);
      int     ev [80];
      int     er [80];
      int     ec [80];
      int     ew [80];
      int     rl [80];
      int     stall [4];
      longint res [4];
      int     s;
      int     t_end;
      stall = '{st0, st1, st2, st3};
      for (int i = 0; i < 80; i++) begin
         ev[i] = 0; er[i] = 0; ec[i] = 0; ew[i] = 0; rl[i] = 0;
      end
      s = 1;
      for (int n = 0; n < 4; n++) begin
         res[n] = convRef(tile, kern, n);
         for (int t = 0; t < 9; t++) begin
            er[s + t] = n / 2 + t / 3;
            ec[s + t] = n % 2 + t % 3;
         end
         for (int e = 0; e <= stall[n]; e++) begin
            ev[s + 9 + e] = 1;
            ew[s + 9 + e] = n;
            if (e < stall[n]) rl[s + 9 + e] = 1;
         end
         s += 10 + stall[n];
      end
      t_end = s - 1;

      @(negedge clk);
      tile_valid = 1'b1;
      tile_in    = tile;
      kernel_in  = kern;
      out_ready  = 1'($urandom % 2);
      #1;
      checkOutput("hs_tile_ready", longint'(tile_ready), 1);
      checkOutput("hs_buf_ld", longint'(buf_ld), 1);

      for (int c = 1; c <= t_end; c++) begin
         @(negedge clk);
         tile_valid = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom % 2) : 1'b0;
         tile_in    = randTile();
         kernel_in  = randKern();
         out_ready  = (ev[c] != 0) ? (rl[c] == 0) : 1'($urandom % 2);
         if (c == abort_at) begin
            rst        = 1'b1;
            tile_valid = 1'b1;
            #1;
            checkOutput("rst_out_valid", longint'(out_valid), 0);
            checkOutput("rst_tile_ready", longint'(tile_ready), 0);
            checkOutput("rst_buf_ld", longint'(buf_ld), 0);
            checkOutput("rst_buf_row", longint'(buf_row), 0);
            checkOutput("rst_buf_col", longint'(buf_col), 0);
            checkOutput("rst_out_data", longint'(out_data), 0);
            checkOutput("rst_out_idx", longint'(out_idx), 0);
            checkOutput("rst_out_last", longint'(out_last), 0);
            repeat (2) @(negedge clk);
            tile_valid = 1'b0;
            rst        = 1'b0;
            #1;
            checkOutput("post_rst_tile_ready", longint'(tile_ready), 1);
            return;
         end
         #1;
         checkOutput("out_valid", longint'(out_valid), longint'(ev[c]));
         checkOutput("buf_row", longint'(buf_row), longint'(er[c]));
         checkOutput("buf_col", longint'(buf_col), longint'(ec[c]));
         checkOutput("busy_tile_ready", longint'(tile_ready), 0);
         checkOutput("busy_buf_ld", longint'(buf_ld), 0);
         if (ev[c] != 0) begin
            checkOutput("out_data", longint'(out_data), res[ew[c]]);
            checkOutput("out_idx", longint'(out_idx), longint'(ew[c]));
            checkOutput("out_last", longint'(out_last), longint'(ew[c] == 3));
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      tile_valid = 1'b1;
      out_ready  = 1'b1;
      tile_in    = '0;
      kernel_in  = '0;
      #2;
      checkOutput("reset_tile_ready", longint'(tile_ready), 0);
      checkOutput("reset_buf_ld", longint'(buf_ld), 0);
      checkOutput("reset_out_valid", longint'(out_valid), 0);
      checkOutput("reset_buf_row", longint'(buf_row), 0);
      checkOutput("reset_buf_col", longint'(buf_col), 0);
      checkOutput("reset_out_data", longint'(out_data), 0);
      checkOutput("reset_out_idx", longint'(out_idx), 0);
      checkOutput("reset_out_last", longint'(out_last), 0);
      repeat (2) @(negedge clk);
      tile_valid = 1'b0;
      rst        = 1'b0;
      #1;
      checkOutput("idle_tile_ready", longint'(tile_ready), 1);
      checkOutput("idle_buf_ld", longint'(buf_ld), 0);

      $display("[TB] all ones");
      applyStimulus({16{8'h01}}, {9{8'h01}}, 0, 0, 0, 0, 0, 0);
      idleCycles(1);

      $display("[TB] address walk");
      applyStimulus(128'h000102030405060708090A0B0C0D0E0F, 72'h000000000100000000, 0, 0, 0, 0, 0, 0);
      idleCycles(1);

      $display("[TB] negative sums");
      applyStimulus({16{8'hFF}}, {9{8'h80}}, 0, 0, 0, 0, 0, 0);
      idleCycles(2);

      $display("[TB] backpressure with tile_valid during stall");
      applyStimulus(randTile(), randKern(), 0, 5, 0, 0, 1, 0);
      idleCycles(1);

      $display("[TB] reset mid-SCAN");
      applyStimulus(randTile(), randKern(), 0, 0, 0, 0, 2, 14);
      applyStimulus({16{8'h03}}, 72'h020000000000000000, 0, 0, 0, 0, 0, 0);
      idleCycles(1);

      $display("[TB] back-to-back tiles");
      applyStimulus(randTile(), randKern(), 0, 0, 0, 0, 1, 0);
      applyStimulus(randTile(), randKern(), 0, 0, 0, 0, 1, 0);
      idleCycles(1);

      $display("[TB] random tiles");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(randTile(), randKern(),
                       int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                       2, 0);
         idleCycles(int'($urandom % 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
